// File: rtl/trigger_sequencer_pkg.sv
// Shared definitions for the trigger sequencer: state encoding, counter and
// pulse index widths, and the parameter range helper.
package trig_pkg;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [IDX_W-1:0] idx_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LOW   = 2'd3;

    function automatic bit in_range(input int unsigned v, input int unsigned hi);
        return (v >= 1) && (v <= hi);
    endfunction

endpackage

// File: rtl/trigger_sequencer_if.sv
// Control/status bundle between a sequencer user (master) and the
// trigger_sequencer block (slave).
interface trigger_sequencer_if;
    import trig_pkg::*;

    logic on;
    logic start;
    logic signal;
    logic busy;
    logic done;
    idx_t pulse_idx;

    modport master (
        output on,
        output start,
        input  signal,
        input  busy,
        input  done,
        input  pulse_idx
    );

    modport slave (
        input  on,
        input  start,
        output signal,
        output busy,
        output done,
        output pulse_idx
    );

endinterface

// File: rtl/trigger_sequencer_counter.sv
// Loadable down-counter shared by the DELAY, HIGH and LOW phases; it saturates
// at zero instead of wrapping.
module cycle_counter
    import trig_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/trigger_sequencer.sv
// Delayed pulse-train generator: after an accepted start it waits DELAY_CYC
// cycles, then emits PULSES high/low pulses on signal; on=0 aborts.
module trigger_sequencer
    import trig_pkg::*;
#(
    parameter int unsigned DELAY_CYC = 5,
    parameter int unsigned HIGH_CYC  = 3,
    parameter int unsigned LOW_CYC   = 3,
    parameter int unsigned PULSES    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    trigger_sequencer_if.slave bus
);

    if (!in_range(DELAY_CYC, 255)) begin : g_bad_delay
        $fatal(1, "trigger_sequencer: DELAY_CYC=%0d outside 1..255", DELAY_CYC);
    end
    if (!in_range(HIGH_CYC, 255)) begin : g_bad_high
        $fatal(1, "trigger_sequencer: HIGH_CYC=%0d outside 1..255", HIGH_CYC);
    end
    if (!in_range(LOW_CYC, 255)) begin : g_bad_low
        $fatal(1, "trigger_sequencer: LOW_CYC=%0d outside 1..255", LOW_CYC);
    end
    if (!in_range(PULSES, 15)) begin : g_bad_pulses
        $fatal(1, "trigger_sequencer: PULSES=%0d outside 1..15", PULSES);
    end

    localparam cnt_t DELAY_LD = cnt_t'(DELAY_CYC - 1);
    localparam cnt_t HIGH_LD  = cnt_t'(HIGH_CYC - 1);
    localparam cnt_t LOW_LD   = cnt_t'(LOW_CYC - 1);
    localparam idx_t LAST_IDX = idx_t'(PULSES - 1);

    logic [1:0] state;
    logic       signal_r;
    logic       busy_r;
    logic       done_r;
    idx_t       pulse_idx_r;

    logic       cnt_load;
    logic       cnt_en;
    cnt_t       cnt_val;
    logic       cnt_zero;

    logic       accept;
    logic       abort;
    logic       last_pulse;

    assign accept     = (state == ST_IDLE) && bus.start && bus.on;
    assign abort      = (state != ST_IDLE) && !bus.on;
    assign last_pulse = (pulse_idx_r == LAST_IDX);

    // The counter is reloaded on each phase entry with (length-1), so
    // expiry at zero marks the last cycle of the phase.
    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    cnt_val  = DELAY_LD;
                end
            end
            ST_DELAY, ST_LOW: begin
                if (bus.on) begin
                    if (cnt_zero) begin
                        cnt_load = 1'b1;
                        cnt_val  = HIGH_LD;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_HIGH: begin
                if (bus.on) begin
                    if (cnt_zero) begin
                        cnt_load = !last_pulse;
                        cnt_val  = LOW_LD;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    cycle_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            signal_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pulse_idx_r <= '0;
        end else begin
            done_r <= 1'b0;
            // Abort outranks every expiry, including the final one, so a
            // sequence cut short never strobes done.
            if (abort) begin
                state    <= ST_IDLE;
                signal_r <= 1'b0;
                busy_r   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            state       <= ST_DELAY;
                            busy_r      <= 1'b1;
                            pulse_idx_r <= '0;
                        end
                    end
                    ST_DELAY, ST_LOW: begin
                        if (cnt_zero) begin
                            state    <= ST_HIGH;
                            signal_r <= 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (cnt_zero) begin
                            signal_r    <= 1'b0;
                            pulse_idx_r <= pulse_idx_r + idx_t'(1);
                            if (last_pulse) begin
                                state  <= ST_IDLE;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                            end else begin
                                state <= ST_LOW;
                            end
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        signal_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.signal    = signal_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pulse_idx = pulse_idx_r;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: table-driven vectors against a
// closed-form waveform model, plus hand-written reset and back-to-back cases.
module tb_trigger_sequencer;

    localparam int D = 5;
    localparam int H = 3;
    localparam int L = 3;
    localparam int P = 2;

    typedef struct packed {
        logic       sig;
        logic       busy;
        logic       done;
        logic [3:0] idx;
    } outs_t;

    typedef struct {
        logic  on;
        logic  start;
        outs_t exp;
    } vec_t;

    typedef struct {
        outs_t exp;
        bit    unit;
        string name;
    } sb_t;

    logic clk;
    logic rst_n;

    trigger_sequencer_if bus ();
    trigger_sequencer_if bus2 ();

    trigger_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    trigger_sequencer #(
        .DELAY_CYC (1),
        .HIGH_CYC  (1),
        .LOW_CYC   (3),
        .PULSES    (1)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    vec_t  tbl[$];
    sb_t   sbq[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // Expected outputs t edges after acceptance (t<0: before acceptance).
    function automatic outs_t model(input int t, input logic [3:0] prev);
        int    total;
        int    u;
        outs_t o;
        total = D + P * H + (P - 1) * L;
        o     = '0;
        if (t < 0) begin
            o.idx = prev;
        end else if (t >= total) begin
            o.idx  = 4'(P);
            o.done = (t == total);
        end else begin
            o.busy = 1'b1;
            u = t - D;
            if (u >= 0) begin
                o.sig = ((u % (H + L)) < H);
                o.idx = 4'((u / (H + L)) + (((u % (H + L)) >= H) ? 1 : 0));
            end
        end
        return o;
    endfunction

    function automatic outs_t idle(input logic [3:0] idx);
        outs_t o;
        o     = '0;
        o.idx = idx;
        return o;
    endfunction

    function automatic void add_row(input logic on_v, input logic st_v, input outs_t e);
        vec_t v;
        v.on    = on_v;
        v.start = st_v;
        v.exp   = e;
        tbl.push_back(v);
    endfunction

    task automatic drain();
        sb_t   it;
        outs_t act;
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            if (it.unit) act = {bus2.signal, bus2.busy, bus2.done, bus2.pulse_idx};
            else         act = {bus.signal, bus.busy, bus.done, bus.pulse_idx};
            n_checks++;
            if (act !== it.exp) begin
                n_errors++;
                $display("FAIL %s @%0t: got sig=%b busy=%b done=%b idx=%0d, want sig=%b busy=%b done=%b idx=%0d",
                         it.name, $time, act.sig, act.busy, act.done, act.idx,
                         it.exp.sig, it.exp.busy, it.exp.done, it.exp.idx);
            end
        end
    endtask

    task automatic expect_now(input bit unit, input outs_t e, input string name);
        sbq.push_back('{e, unit, name});
        drain();
    endtask

    // Drive at the negedge, expect the result of the following posedge.
    task automatic step(input logic on_v, input logic st_v, input outs_t e,
                        input bit unit, input string name);
        if (unit) begin
            bus2.on    = on_v;
            bus2.start = st_v;
        end else begin
            bus.on    = on_v;
            bus.start = st_v;
        end
        sbq.push_back('{e, unit, name});
        @(posedge clk);
        @(negedge clk);
        drain();
    endtask

    initial begin
        outs_t ph;

        rst_n      = 1'b1;
        bus.on     = 1'b0;
        bus.start  = 1'b0;
        bus2.on    = 1'b0;
        bus2.start = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        expect_now(1'b0, idle(4'd0), "reset_dut");
        expect_now(1'b1, idle(4'd0), "reset_dut2");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Default waveform with extra start pulses while busy and on the busy-fall edge.
        for (int r = 0; r < 25; r++)
            add_row(1'b1, (r == 5) || (r == 7) || (r == 11) || (r == 15) || (r == 19), model(r - 5, 4'd0));
        // start with on=0 ignored, then a real start two cycles later.
        for (int r = 0; r < 22; r++)
            add_row(r != 0, (r == 0) || (r == 2), model(r - 2, 4'd2));
        // on dropped during first HIGH; start while on=0 is ignored.
        for (int r = 0; r < 11; r++)
            add_row(!((r >= 6) && (r <= 9)), (r == 0) || (r == 8), (r < 6) ? model(r, 4'd2) : idle(4'd0));
        // on dropped on the very edge the final HIGH expires: no done.
        for (int r = 0; r < 17; r++)
            add_row(r != 14, r == 0, (r < 14) ? model(r, 4'd0) : idle(4'd1));
        // on dropped during LOW.
        for (int r = 0; r < 12; r++)
            add_row(r != 9, r == 0, (r < 9) ? model(r, 4'd1) : idle(4'd1));

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].on, tbl[i].start, tbl[i].exp, 1'b0, $sformatf("vec%0d", i));

        // Asynchronous reset between edges during LOW.
        for (int t = 0; t <= 10; t++)
            step(1'b1, t == 0, model(t, 4'd1), 1'b0, $sformatf("pre_rst_t%0d", t));
        #2 rst_n = 1'b0;
        #1;
        expect_now(1'b0, idle(4'd0), "async_rst_dut");
        expect_now(1'b1, idle(4'd0), "async_rst_dut2");
        @(negedge clk);
        expect_now(1'b0, idle(4'd0), "held_rst_dut");
        rst_n = 1'b1;
        for (int t = 0; t <= 16; t++)
            step(1'b1, t == 0, model(t, 4'd0), 1'b0, $sformatf("post_rst_t%0d", t));

        // start held high on the minimal configuration: accept, HIGH, IDLE, repeat.
        bus.on    = 1'b1;
        bus.start = 1'b0;
        for (int j = 0; j < 12; j++) begin
            case (j % 3)
                0:       ph = '{1'b0, 1'b1, 1'b0, 4'd0};
                1:       ph = '{1'b1, 1'b1, 1'b0, 4'd0};
                default: ph = '{1'b0, 1'b0, 1'b1, 4'd1};
            endcase
            step(1'b1, 1'b1, ph, 1'b1, $sformatf("hold%0d", j));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
